// File: rtl/wptr_ctrl_lvl.sv
// Write-side pointer/level controller for the async FIFO; optional sticky overflow under FIFO_WOVF_EN.
// Latency: waddr combinational from wbin; wptr/full/almost_full/wlevel registered one cycle after the write.
// Backpressure: writes are dropped while full is high; the write port must honour full.
module wptr_ctrl_lvl #(
    parameter int AW        = 4,
    parameter int AF_THRESH = (2**AW) - 2
) (
    input  logic          clk,
    input  logic          wresetn,
    input  logic          winc,
    input  logic [AW:0]   wq2rptr,
    input  logic          ovf_clr,
    output logic [AW-1:0] waddr,
    output logic [AW:0]   wptr,
    output logic          full,
    output logic          almost_full,
    output logic [AW:0]   wlevel,
    output logic          overflow
);

    localparam logic [AW:0] AF_LVL = AF_THRESH[AW:0];

    logic [AW:0] wbin;
    logic [AW:0] wbin_next;
    logic [AW:0] wgray_next;
    logic [AW:0] rbin;
    logic [AW:0] level_next;
    logic        wen;
    logic        full_next;
    logic        af_next;

    assign wen        = winc & ~full;
    assign wbin_next  = wbin + {{AW{1'b0}}, wen};
    assign wgray_next = wbin_next ^ (wbin_next >> 1);
    assign waddr      = wbin[AW-1:0];

    always_comb begin
        rbin = '0;
        for (int i = 0; i <= AW; i++) begin
            rbin[i] = ^(wq2rptr >> i);
        end
    end

    // Single subtraction so a write and a read-pointer advance in the same cycle never glitch the level.
    assign level_next = wbin_next - rbin;
    assign full_next  = (wgray_next == {~wq2rptr[AW:AW-1], wq2rptr[AW-2:0]});
    assign af_next    = (level_next >= AF_LVL);

    always_ff @(posedge clk or negedge wresetn) begin
        if (!wresetn) begin
            wbin        <= '0;
            wptr        <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wlevel      <= '0;
        end else begin
            wbin        <= wbin_next;
            wptr        <= wgray_next;
            full        <= full_next;
            almost_full <= af_next;
            wlevel      <= level_next;
        end
    end

`ifdef FIFO_WOVF_EN
    // Set has priority over clear so a write lost in the clearing cycle is still reported.
    always_ff @(posedge clk or negedge wresetn) begin
        if (!wresetn) begin
            overflow <= 1'b0;
        end else if (winc && full) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_ctrl_lvl.sv
// Directed bench for wptr_ctrl_lvl at AW=4, AF_THRESH=14; overflow expectations follow FIFO_WOVF_EN.
module tb_wptr_ctrl_lvl;

    logic       clk = 1'b0;
    logic       wresetn;
    logic       winc;
    logic [4:0] wq2rptr;
    logic       ovf_clr;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       full;
    logic       almost_full;
    logic [4:0] wlevel;
    logic       overflow;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef FIFO_WOVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    wptr_ctrl_lvl #(.AW(4), .AF_THRESH(14)) dut (
        .clk(clk), .wresetn(wresetn), .winc(winc), .wq2rptr(wq2rptr), .ovf_clr(ovf_clr),
        .waddr(waddr), .wptr(wptr), .full(full), .almost_full(almost_full),
        .wlevel(wlevel), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_waddr"}, 32'(waddr), 0);
        check({tag, "_wptr"}, 32'(wptr), 0);
        check({tag, "_full"}, 32'(full), 0);
        check({tag, "_af"}, 32'(almost_full), 0);
        check({tag, "_wlevel"}, 32'(wlevel), 0);
        check({tag, "_ovf"}, 32'(overflow), 0);
    endtask

    logic [4:0] w;

    initial begin
        wresetn = 1'b0;
        winc    = 1'b1;
        wq2rptr = '0;
        ovf_clr = 1'b0;
        w       = '0;
        repeat (3) step();
        check_zero("rst");

        // Gray sequence on the first writes after reset release
        wresetn = 1'b1;
        step(); check("gray1", 32'(wptr), 32'h01);
        step(); check("gray2", 32'(wptr), 32'h03);
        step(); check("gray3", 32'(wptr), 32'h02);
        step(); check("gray4", 32'(wptr), 32'h06);
        check("waddr4", 32'(waddr), 4);

        // Fill to 16
        for (int n = 5; n <= 16; n++) begin
            step();
            if (n == 13) check("af_13", 32'(almost_full), 0);
            if (n == 14) check("af_14", 32'(almost_full), 1);
            if (n == 15) check("full_15", 32'(full), 0);
        end
        check("full_16", 32'(full), 1);
        check("lvl_16", 32'(wlevel), 16);
        check("wptr_16", 32'(wptr), 32'h18);
        check("waddr_16", 32'(waddr), 0);

        // Writes while full are dropped
        repeat (3) step();
        check("hold_wptr", 32'(wptr), 32'h18);
        check("hold_lvl", 32'(wlevel), 16);
        check("hold_waddr", 32'(waddr), 0);
        check("hold_full", 32'(full), 1);
        check("ovf_set", 32'(overflow), 32'(OVF));

        // One read frees a slot
        winc = 1'b0;
        wq2rptr = gray(5'd1);
        step();
        check("rd1_full", 32'(full), 0);
        check("rd1_lvl", 32'(wlevel), 15);
        check("rd1_af", 32'(almost_full), 1);
        check("rd1_ovf", 32'(overflow), 32'(OVF));

        winc = 1'b1;
        step();
        check("refill_full", 32'(full), 1);
        check("refill_wptr", 32'(wptr), 32'h19);
        ovf_clr = 1'b1;
        step();
        check("set_wins", 32'(overflow), 32'(OVF));
        winc = 1'b0;
        step();
        check("ovf_clr", 32'(overflow), 0);
        ovf_clr = 1'b0;

        // Wrap with read pointer trailing so level settles at 3
        w = 5'd17;
        wq2rptr = gray(w - 5'd2);
        step();
        check("pre_wrap_lvl", 32'(wlevel), 2);
        winc = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wq2rptr = gray(w - 5'd2);
            step();
            w = w + 5'd1;
            check("wrap_lvl", 32'(wlevel), 3);
            check("wrap_full", 32'(full), 0);
            check("wrap_af", 32'(almost_full), 0);
            check("wrap_wptr", 32'(wptr), 32'(gray(w)));
        end
        check("wrap_waddr", 32'(waddr), 32'(w[3:0]));
        check("wrap_end", 32'(w), 25);

        // Reset mid-stream
        wq2rptr = gray(w - 5'd8);
        step();
        check("pre_rst_lvl", 32'(wlevel), 9);
        wresetn = 1'b0;
        #1;
        check_zero("async_rst");
        wq2rptr = '0;
        winc = 1'b0;
        step();
        wresetn = 1'b1;
        winc = 1'b1;
        step();
        check("post_rst_lvl", 32'(wlevel), 1);
        check("post_rst_wptr", 32'(wptr), 1);
        check("post_rst_waddr", 32'(waddr), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
